// File: rtl/greenhouse_display_pkg.sv
// greenhouse_display_pkg: shared BCD field layout, status width, FSM states
// and the BCD validity check for the display update arbiter.
package greenhouse_display_pkg;

    localparam int BCD_W    = 10;
    localparam int STAT_W   = 4;
    localparam int ONES_LSB = 0;
    localparam int TENS_LSB = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_DROP} state_t;

    // Hundreds is only two bits wide and can never be out of range.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] t);
        return (t[TENS_LSB +: 4] <= BCD_MAX) && (t[ONES_LSB +: 4] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_grant+1.
// Ports:
//   req        in  NUM_SRC  request vector
//   last_grant in  IW       index granted most recently
//   grant      out IW       winning index (valid when any_req)
//   any_req    out 1        at least one request pending
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant,
    output logic               any_req
);

    logic [IW-1:0] idx;
    logic          found;

    assign any_req = |req;

    always_comb begin
        grant = last_grant;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_update_arbiter.sv
// display_update_arbiter: shares the display datapath between NUM_SRC modules;
// posts are captured into shadows over REQ/ACK and committed on FRAME_START.
// Ports:
//   CLOCK_50     in   system clock
//   RESET_N      in   asynchronous active-low reset
//   FRAME_START  in   one-cycle vertical-blank pulse
//   SRC_REQ      in   per-source post request
//   SRC_TEMP     in   packed BCD temperatures, source i at [i*TEMP_W +: TEMP_W]
//   SRC_STATUS   in   packed status words
//   SRC_ACK      out  per-source acknowledge, one-hot or zero
//   DISP_TEMP    out  live temperatures
//   DISP_STATUS  out  live status words
//   DISP_STALE   out  source has not committed for STALE_FRAMES frames
//   SRC_ERR      out  last post from the source had an invalid BCD digit
//   BUSY         out  FSM not idle
module display_update_arbiter
    import greenhouse_display_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int TEMP_W       = BCD_W,
    parameter int STATUS_W     = STAT_W,
    parameter int STALE_FRAMES = 60
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic                         FRAME_START,
    input  logic [NUM_SRC-1:0]           SRC_REQ,
    input  logic [NUM_SRC*TEMP_W-1:0]    SRC_TEMP,
    input  logic [NUM_SRC*STATUS_W-1:0]  SRC_STATUS,
    output logic [NUM_SRC-1:0]           SRC_ACK,
    output logic [NUM_SRC*TEMP_W-1:0]    DISP_TEMP,
    output logic [NUM_SRC*STATUS_W-1:0]  DISP_STATUS,
    output logic [NUM_SRC-1:0]           DISP_STALE,
    output logic [NUM_SRC-1:0]           SRC_ERR,
    output logic                         BUSY
);

    localparam int IW = $clog2(NUM_SRC);

    state_t                     state, state_next;
    logic [IW-1:0]              g, win, last_grant;
    logic                       any_req, valid;
    logic [NUM_SRC-1:0]         ack, dirty, stale, err, g_mask, cap;
    logic [TEMP_W-1:0]          temp_in;
    logic [STATUS_W-1:0]        status_in;
    logic [TEMP_W-1:0]          shadow_temp   [NUM_SRC];
    logic [STATUS_W-1:0]        shadow_status [NUM_SRC];
    logic [7:0]                 frame_cnt     [NUM_SRC];
    logic [NUM_SRC*TEMP_W-1:0]  live_temp;
    logic [NUM_SRC*STATUS_W-1:0] live_status;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req        (SRC_REQ),
        .last_grant (last_grant),
        .grant      (win),
        .any_req    (any_req)
    );

    assign temp_in   = SRC_TEMP[g*TEMP_W +: TEMP_W];
    assign status_in = SRC_STATUS[g*STATUS_W +: STATUS_W];
    assign valid     = bcd_valid(temp_in);
    assign g_mask    = NUM_SRC'(1) << g;
    assign cap       = (state == GRANT && valid) ? g_mask : '0;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = any_req ? GRANT : IDLE;
            GRANT:     state_next = WAIT_DROP;
            WAIT_DROP: state_next = SRC_REQ[g] ? WAIT_DROP : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            g          <= '0;
            last_grant <= IW'(NUM_SRC - 1);
            ack        <= '0;
        end else begin
            if (state == IDLE && any_req) g <= win;
            if (state == GRANT) begin
                ack        <= g_mask;
                last_grant <= g;
            end
            if (state == WAIT_DROP && !SRC_REQ[g]) ack <= '0;
        end
    end

    // A capture in the same cycle as FRAME_START re-sets dirty after the
    // commit clears it, so the new value goes out on the following frame.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dirty       <= '0;
            stale       <= '0;
            err         <= '0;
            live_temp   <= '0;
            live_status <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                shadow_temp[i]   <= '0;
                shadow_status[i] <= '0;
                frame_cnt[i]     <= '0;
            end
        end else begin
            dirty <= (FRAME_START ? '0 : dirty) | cap;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (FRAME_START && dirty[i]) begin
                    live_temp[i*TEMP_W +: TEMP_W]       <= shadow_temp[i];
                    live_status[i*STATUS_W +: STATUS_W] <= shadow_status[i];
                    frame_cnt[i] <= '0;
                    stale[i]     <= 1'b0;
                end else if (FRAME_START) begin
                    frame_cnt[i] <= (frame_cnt[i] == 8'(STALE_FRAMES)) ? frame_cnt[i] : frame_cnt[i] + 8'd1;
                    stale[i]     <= frame_cnt[i] == 8'(STALE_FRAMES);
                end
            end
            if (state == GRANT) begin
                err[g] <= !valid;
                if (valid) begin
                    shadow_temp[g]   <= temp_in;
                    shadow_status[g] <= status_in;
                end
            end
        end
    end

    assign SRC_ACK     = ack;
    assign DISP_TEMP   = live_temp;
    assign DISP_STATUS = live_status;
    assign DISP_STALE  = stale;
    assign SRC_ERR     = err;
    assign BUSY        = state != IDLE;

endmodule

// File: tb/tb_display_update_arbiter.sv
// tb_display_update_arbiter: scoreboard bench for display_update_arbiter;
// expected grant order is queued when requests are raised and popped on ACK.
module tb_display_update_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int TEMP_W   = 10;
    localparam int STATUS_W = 4;

    logic                         CLOCK_50 = 1'b0;
    logic                         RESET_N = 1'b0;
    logic                         FRAME_START = 1'b0;
    logic [NUM_SRC-1:0]           SRC_REQ = '0;
    logic [NUM_SRC*TEMP_W-1:0]    SRC_TEMP = '0;
    logic [NUM_SRC*STATUS_W-1:0]  SRC_STATUS = '0;
    logic [NUM_SRC-1:0]           SRC_ACK;
    logic [NUM_SRC*TEMP_W-1:0]    DISP_TEMP;
    logic [NUM_SRC*STATUS_W-1:0]  DISP_STATUS;
    logic [NUM_SRC-1:0]           DISP_STALE;
    logic [NUM_SRC-1:0]           SRC_ERR;
    logic                         BUSY;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_grant [$];

    display_update_arbiter #(.NUM_SRC(NUM_SRC), .TEMP_W(TEMP_W), .STATUS_W(STATUS_W), .STALE_FRAMES(2)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .FRAME_START (FRAME_START),
        .SRC_REQ     (SRC_REQ),
        .SRC_TEMP    (SRC_TEMP),
        .SRC_STATUS  (SRC_STATUS),
        .SRC_ACK     (SRC_ACK),
        .DISP_TEMP   (DISP_TEMP),
        .DISP_STATUS (DISP_STATUS),
        .DISP_STALE  (DISP_STALE),
        .SRC_ERR     (SRC_ERR),
        .BUSY        (BUSY)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic frame();
        @(negedge CLOCK_50);
        FRAME_START = 1'b1;
        @(negedge CLOCK_50);
        FRAME_START = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [9:0] t, input logic [3:0] s);
        SRC_TEMP[i*TEMP_W +: TEMP_W]       = t;
        SRC_STATUS[i*STATUS_W +: STATUS_W] = s;
    endtask

    task automatic idle_wait();
        int c;
        c = 0;
        while (BUSY && c < 20) begin
            @(negedge CLOCK_50);
            c++;
        end
        check("idle", BUSY, 0);
    endtask

    // Drops each source's REQ as soon as it sees its ACK.
    task automatic serve(input int n);
        int got;
        got = 0;
        for (int c = 0; c < 100 && got < n; c++) begin
            @(negedge CLOCK_50);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (SRC_ACK[i] && SRC_REQ[i]) begin
                    if (exp_grant.size() == 0) check("grant_unexpected", i, 99);
                    else check("grant_order", i, exp_grant.pop_front());
                    SRC_REQ[i] = 1'b0;
                    got++;
                end
            end
        end
        if (got != n) check("serve_timeout", got, n);
        idle_wait();
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        cyc(2);
        RESET_N = 1'b1;
    endtask

    initial begin
        cyc(2);
        check("rst_temp", DISP_TEMP, 0);
        check("rst_status", DISP_STATUS, 0);
        check("rst_stale", DISP_STALE, 0);
        check("rst_err", SRC_ERR, 0);
        check("rst_ack", SRC_ACK, 0);
        check("rst_busy", BUSY, 0);
        RESET_N = 1'b1;
        frame();
        frame();
        check("stale_f2", DISP_STALE, 4'b0000);
        frame();
        check("stale_f3", DISP_STALE, 4'b1111);
        check("idle_temp", DISP_TEMP, 0);

        set_src(1, 10'h275, 4'h3);
        SRC_REQ[1] = 1'b1;
        exp_grant.push_back(1);
        cyc(1);
        check("ack_lat1", SRC_ACK, 4'b0000);
        cyc(1);
        check("ack_lat2", SRC_ACK, 4'b0010);
        serve(1);
        check("pre_frame_temp1", DISP_TEMP[1*TEMP_W +: TEMP_W], 0);
        frame();
        check("temp1", DISP_TEMP[1*TEMP_W +: TEMP_W], 10'h275);
        check("status1", DISP_STATUS[1*STATUS_W +: STATUS_W], 4'h3);
        check("stale1", DISP_STALE, 4'b1101);

        do_reset();
        check("rst2_temp", DISP_TEMP, 0);
        set_src(0, 10'h100, 4'h1);
        set_src(2, 10'h042, 4'h2);
        set_src(3, 10'h063, 4'h4);
        SRC_REQ = 4'b1101;
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        serve(3);
        set_src(0, 10'h118, 4'h6);
        set_src(3, 10'h209, 4'h7);
        SRC_REQ = 4'b1001;
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        serve(2);
        check("rr_queue_empty", exp_grant.size(), 0);
        frame();
        check("rr_temp", DISP_TEMP, {10'h209, 10'h042, 10'h000, 10'h118});
        check("rr_status", DISP_STATUS, {4'h7, 4'h2, 4'h0, 4'h6});

        set_src(2, 10'h04A, 4'h9);
        SRC_REQ[2] = 1'b1;
        exp_grant.push_back(2);
        serve(1);
        check("err_set", SRC_ERR, 4'b0100);
        frame();
        check("bad_temp2", DISP_TEMP[2*TEMP_W +: TEMP_W], 10'h042);
        check("bad_status2", DISP_STATUS[2*STATUS_W +: STATUS_W], 4'h2);
        set_src(2, 10'h081, 4'h5);
        SRC_REQ[2] = 1'b1;
        exp_grant.push_back(2);
        serve(1);
        check("err_clr", SRC_ERR, 4'b0000);
        frame();
        check("good_temp2", DISP_TEMP[2*TEMP_W +: TEMP_W], 10'h081);
        check("good_status2", DISP_STATUS[2*STATUS_W +: STATUS_W], 4'h5);

        set_src(0, 10'h150, 4'h1);
        SRC_REQ[0] = 1'b1;
        exp_grant.push_back(0);
        serve(1);
        set_src(0, 10'h199, 4'h8);
        SRC_REQ[0] = 1'b1;
        cyc(1);
        check("coin_grant_busy", BUSY, 1);
        FRAME_START = 1'b1;
        cyc(1);
        FRAME_START = 1'b0;
        check("coin_ack", SRC_ACK, 4'b0001);
        check("coin_old", DISP_TEMP[0 +: TEMP_W], 10'h150);
        exp_grant.push_back(0);
        serve(1);
        frame();
        check("coin_new", DISP_TEMP[0 +: TEMP_W], 10'h199);
        check("coin_status", DISP_STATUS[0 +: STATUS_W], 4'h8);

        set_src(3, 10'h055, 4'hA);
        SRC_REQ[3] = 1'b1;
        cyc(2);
        check("wd_ack", SRC_ACK, 4'b1000);
        @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        check("async_ack", SRC_ACK, 0);
        check("async_busy", BUSY, 0);
        check("async_temp", DISP_TEMP, 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        exp_grant.push_back(3);
        serve(1);
        frame();
        check("rst_reserve", DISP_TEMP, {10'h055, 30'h0});
        check("rst_reserve_st", DISP_STATUS, {4'hA, 12'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
